// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen: quadrature (F/B) pin pattern generator for encoder emulation.
// Accepts signed step commands through a valid/ready handshake, walks the
// two-phase Gray sequence one pin edge per step at a programmable period,
// and keeps a signed running position that software can overwrite.
//
// Ports:
//   clk, resetn          - system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  - command handshake (ready only while idle)
//   cmd_steps            - signed edge count (>0 forward, <0 reverse)
//   cmd_period           - clk cycles between edges (0 behaves as 1)
//   abort                - stop the current run without a done pulse
//   writeEncoder         - load position from setEncoderData
//   busy, done           - run in progress / one-cycle completion pulse
//   position             - signed running edge count (wraps)
//   pinEncoderF/B        - quadrature outputs, F leads B when moving forward
module quad_encoder_gen #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    input  logic             writeEncoder,
    input  logic [CNT_W-1:0] setEncoderData,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] position,
    output logic             pinEncoderF,
    output logic             pinEncoderB
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_pin_f;
    logic             r_pin_b;
    logic [CNT_W-1:0] r_position;
    logic [CNT_W-1:0] r_remaining;
    logic [DIV_W-1:0] r_divider;
    logic [DIV_W-1:0] r_period;
    logic             r_dir;          // 1 = reverse
    logic             r_done;
    logic             r_busy;
    logic             r_cmd_ready;

    state_t           w_state_nxt;
    logic             w_pin_f_nxt;
    logic             w_pin_b_nxt;
    logic [CNT_W-1:0] w_position_nxt;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic [DIV_W-1:0] w_divider_nxt;
    logic [DIV_W-1:0] w_period_nxt;
    logic             w_dir_nxt;
    logic             w_done_nxt;
    logic             w_step;
    logic [CNT_W-1:0] w_magnitude;
    logic [DIV_W-1:0] w_cmd_period;

    // Magnitude as unsigned so the most negative count maps to 2^(CNT_W-1)
    assign w_magnitude  = cmd_steps[CNT_W-1] ? CNT_W'(CNT_W'(0) - cmd_steps) : cmd_steps;
    assign w_cmd_period = (cmd_period == DIV_W'(0)) ? DIV_W'(1) : cmd_period;
    assign w_step       = (r_state == S_RUN) && (r_divider == DIV_W'(0));

    // Next-state and datapath
    always_comb begin
        w_state_nxt     = r_state;
        w_pin_f_nxt     = r_pin_f;
        w_pin_b_nxt     = r_pin_b;
        w_position_nxt  = r_position;
        w_remaining_nxt = r_remaining;
        w_divider_nxt   = r_divider;
        w_period_nxt    = r_period;
        w_dir_nxt       = r_dir;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_dir_nxt     = cmd_steps[CNT_W-1];
                    w_period_nxt  = w_cmd_period;
                    w_divider_nxt = DIV_W'(w_cmd_period - DIV_W'(1));
                    if (w_magnitude == CNT_W'(0)) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_remaining_nxt = w_magnitude;
                        w_state_nxt     = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_step) begin
                    // Gray walk: forward 00->10->11->01, reverse the opposite way
                    if (r_dir) begin
                        w_pin_f_nxt    = r_pin_b;
                        w_pin_b_nxt    = ~r_pin_f;
                        w_position_nxt = CNT_W'(r_position - CNT_W'(1));
                    end else begin
                        w_pin_f_nxt    = ~r_pin_b;
                        w_pin_b_nxt    = r_pin_f;
                        w_position_nxt = CNT_W'(r_position + CNT_W'(1));
                    end
                    w_remaining_nxt = CNT_W'(r_remaining - CNT_W'(1));
                    w_divider_nxt   = DIV_W'(r_period - DIV_W'(1));
                    if (r_remaining == CNT_W'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = ~abort;
                    end
                end else begin
                    w_divider_nxt = DIV_W'(r_divider - DIV_W'(1));
                end
                if (abort) begin
                    w_state_nxt     = S_IDLE;
                    w_remaining_nxt = CNT_W'(0);
                    w_divider_nxt   = DIV_W'(0);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Software load overrides any same-cycle step increment
        if (writeEncoder) begin
            w_position_nxt = setEncoderData;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_pin_f     <= 1'b0;
            r_pin_b     <= 1'b0;
            r_position  <= CNT_W'(0);
            r_remaining <= CNT_W'(0);
            r_divider   <= DIV_W'(0);
            r_period    <= DIV_W'(1);
            r_dir       <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_pin_f     <= w_pin_f_nxt;
            r_pin_b     <= w_pin_b_nxt;
            r_position  <= w_position_nxt;
            r_remaining <= w_remaining_nxt;
            r_divider   <= w_divider_nxt;
            r_period    <= w_period_nxt;
            r_dir       <= w_dir_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= (w_state_nxt == S_RUN);
            r_cmd_ready <= (w_state_nxt == S_IDLE);
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign position    = r_position;
    assign pinEncoderF = r_pin_f;
    assign pinEncoderB = r_pin_b;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb_quad_encoder_gen: directed vector table plus hand-written sequences for
// abort timing, decoder loopback and asynchronous reset of quad_encoder_gen.
module tb_quad_encoder_gen;

    logic        clk;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_steps;
    logic [15:0] cmd_period;
    logic        abort;
    logic        writeEncoder;
    logic [31:0] setEncoderData;
    logic        busy;
    logic        done;
    logic [31:0] position;
    logic        pinEncoderF;
    logic        pinEncoderB;

    quad_encoder_gen #(.CNT_W(32), .DIV_W(16)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_steps      (cmd_steps),
        .cmd_period     (cmd_period),
        .abort          (abort),
        .writeEncoder   (writeEncoder),
        .setEncoderData (setEncoderData),
        .busy           (busy),
        .done           (done),
        .position       (position),
        .pinEncoderF    (pinEncoderF),
        .pinEncoderB    (pinEncoderB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row: inputs held for one clock, then outputs expected after that edge.
    // exp_ctl = {cmd_ready, busy, done, F, B}
    typedef struct {
        logic        valid;
        logic [31:0] steps;
        logic [15:0] period;
        logic        abrt;
        logic        wr;
        logic [31:0] wdata;
        logic [4:0]  exp_ctl;
        logic [31:0] exp_pos;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic v, input logic [31:0] st, input logic [15:0] pe,
                       input logic ab, input logic wr, input logic [31:0] wd,
                       input logic [4:0] ctl, input logic [31:0] pos);
        vec_t t;
        t.valid = v; t.steps = st; t.period = pe; t.abrt = ab;
        t.wr = wr; t.wdata = wd; t.exp_ctl = ctl; t.exp_pos = pos;
        vecs.push_back(t);
    endtask

    task automatic idle_row(input logic [4:0] ctl, input logic [31:0] pos);
        add(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 32'd0, ctl, pos);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] ctl_now();
        return {cmd_ready, busy, done, pinEncoderF, pinEncoderB};
    endfunction

    // Position of a pin pair in the forward cycle 00,10,11,01
    function automatic int gray_idx(input logic [1:0] fb);
        case (fb)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Independent quadrature decoder: +1, -1, 0, or 100 for an illegal jump
    function automatic int decode(input logic [1:0] prev, input logic [1:0] cur);
        int d;
        d = (gray_idx(cur) - gray_idx(prev) + 4) % 4;
        case (d)
            0:       return 0;
            1:       return 1;
            3:       return -1;
            default: return 100;
        endcase
    endfunction

    int          dec_pos;
    int          dec_bad;
    logic [1:0]  prev_fb;

    task automatic loop_run(input logic [31:0] st, input int budget, input int idx);
        logic got_done;
        int   d;
        got_done     = 1'b0;
        cmd_valid    = 1'b1;
        cmd_steps    = st;
        cmd_period   = 16'd5;
        tick();
        cmd_valid    = 1'b0;
        for (int i = 0; i < budget && !got_done; i++) begin
            tick();
            d = decode(prev_fb, {pinEncoderF, pinEncoderB});
            if (d == 100) dec_bad++;
            else dec_pos += d;
            prev_fb = {pinEncoderF, pinEncoderB};
            if (done) got_done = 1'b1;
        end
        check("loop_done_seen", idx, 32'(got_done), 32'd1);
    endtask

    initial begin
        int edges;
        int bad_busy;
        int early_done;
        logic [1:0] last_fb;

        resetn = 1'b0; cmd_valid = 1'b0; cmd_steps = '0; cmd_period = '0;
        abort = 1'b0; writeEncoder = 1'b0; setEncoderData = '0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        check("reset_ctl", 0, 32'(ctl_now()), 32'(5'b1_0_0_00));
        check("reset_pos", 0, position, 32'd0);

        // +4 steps, period 3: edges at +3,+6,+9,+12
        add(1'b1, 32'd4, 16'd3, 1'b0, 1'b0, 32'd0, 5'b0_1_0_00, 32'd0);
        idle_row(5'b0_1_0_00, 32'd0);
        idle_row(5'b0_1_0_00, 32'd0);
        idle_row(5'b0_1_0_10, 32'd1);
        idle_row(5'b0_1_0_10, 32'd1);
        idle_row(5'b0_1_0_10, 32'd1);
        idle_row(5'b0_1_0_11, 32'd2);
        idle_row(5'b0_1_0_11, 32'd2);
        idle_row(5'b0_1_0_11, 32'd2);
        idle_row(5'b0_1_0_01, 32'd3);
        idle_row(5'b0_1_0_01, 32'd3);
        idle_row(5'b0_1_0_01, 32'd3);
        idle_row(5'b1_0_1_00, 32'd4);
        idle_row(5'b1_0_0_00, 32'd4);
        // load 0, then -3 steps with period 0 (one edge per cycle)
        add(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 32'd0, 5'b1_0_0_00, 32'd0);
        add(1'b1, 32'hFFFF_FFFD, 16'd0, 1'b0, 1'b0, 32'd0, 5'b0_1_0_00, 32'd0);
        idle_row(5'b0_1_0_01, 32'hFFFF_FFFF);
        idle_row(5'b0_1_0_11, 32'hFFFF_FFFE);
        idle_row(5'b1_0_1_10, 32'hFFFF_FFFD);
        idle_row(5'b1_0_0_10, 32'hFFFF_FFFD);
        // load 0x7FFFFFFF, +2 steps wraps through the sign boundary
        add(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 32'h7FFF_FFFF, 5'b1_0_0_10, 32'h7FFF_FFFF);
        add(1'b1, 32'd2, 16'd1, 1'b0, 1'b0, 32'd0, 5'b0_1_0_10, 32'h7FFF_FFFF);
        idle_row(5'b0_1_0_11, 32'h8000_0000);
        idle_row(5'b1_0_1_01, 32'h8000_0001);
        idle_row(5'b1_0_0_01, 32'h8000_0001);
        // load on the same edge as the final step: load value wins, pins still move
        add(1'b1, 32'd1, 16'd2, 1'b0, 1'b0, 32'd0, 5'b0_1_0_01, 32'h8000_0001);
        idle_row(5'b0_1_0_01, 32'h8000_0001);
        add(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 32'h1234_5678, 5'b1_0_1_00, 32'h1234_5678);
        idle_row(5'b1_0_0_00, 32'h1234_5678);
        // zero steps with abort in idle: accepted, done next cycle, pins unchanged
        add(1'b1, 32'd0, 16'd7, 1'b1, 1'b0, 32'd0, 5'b1_0_1_00, 32'h1234_5678);
        idle_row(5'b1_0_0_00, 32'h1234_5678);
        // most negative count runs in reverse and is not treated as zero
        add(1'b0, 32'd0, 16'd0, 1'b0, 1'b1, 32'd0, 5'b1_0_0_00, 32'd0);
        add(1'b1, 32'h8000_0000, 16'd2, 1'b0, 1'b0, 32'd0, 5'b0_1_0_00, 32'd0);
        idle_row(5'b0_1_0_00, 32'd0);
        idle_row(5'b0_1_0_01, 32'hFFFF_FFFF);
        add(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 32'd0, 5'b1_0_0_01, 32'hFFFF_FFFF);
        idle_row(5'b1_0_0_01, 32'hFFFF_FFFF);
        // abort on the final edge: edge happens, done suppressed
        add(1'b1, 32'd1, 16'd1, 1'b0, 1'b0, 32'd0, 5'b0_1_0_01, 32'hFFFF_FFFF);
        add(1'b0, 32'd0, 16'd0, 1'b1, 1'b0, 32'd0, 5'b1_0_0_00, 32'd0);
        idle_row(5'b1_0_0_00, 32'd0);

        foreach (vecs[i]) begin
            cmd_valid      = vecs[i].valid;
            cmd_steps      = vecs[i].steps;
            cmd_period     = vecs[i].period;
            abort          = vecs[i].abrt;
            writeEncoder   = vecs[i].wr;
            setEncoderData = vecs[i].wdata;
            tick();
            check("vec_ctl", i, 32'(ctl_now()), 32'(vecs[i].exp_ctl));
            check("vec_pos", i, position, vecs[i].exp_pos);
        end
        cmd_valid = 1'b0; abort = 1'b0; writeEncoder = 1'b0;

        // abort 35 cycles into a 100-step run; a held command waits until then
        cmd_valid = 1'b1; cmd_steps = 32'd100; cmd_period = 16'd10;
        tick();
        check("abort_busy", 0, 32'(busy), 32'd1);
        cmd_steps = 32'd2; cmd_period = 16'd1;
        edges = 0; bad_busy = 0; early_done = 0;
        last_fb = {pinEncoderF, pinEncoderB};
        for (int k = 1; k <= 34; k++) begin
            tick();
            if ({pinEncoderF, pinEncoderB} != last_fb) edges++;
            last_fb = {pinEncoderF, pinEncoderB};
            if (!busy || cmd_ready) bad_busy++;
            if (done) early_done++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        if ({pinEncoderF, pinEncoderB} != last_fb) edges++;
        check("abort_edges", 0, 32'(edges), 32'd3);
        check("abort_held_ignored", 0, 32'(bad_busy), 32'd0);
        check("abort_no_done_run", 0, 32'(early_done), 32'd0);
        check("abort_ctl", 0, 32'(ctl_now()), 32'(5'b1_0_0_01));
        check("abort_pos", 0, position, 32'd3);
        tick();
        cmd_valid = 1'b0;
        check("held_accept_ctl", 0, 32'(ctl_now()), 32'(5'b0_1_0_01));
        tick();
        check("held_run_ctl", 0, 32'(ctl_now()), 32'(5'b0_1_0_00));
        check("held_run_pos", 0, position, 32'd4);
        tick();
        check("held_done_ctl", 0, 32'(ctl_now()), 32'(5'b1_0_1_10));
        check("held_done_pos", 0, position, 32'd5);

        // loopback: +1000 then -250 at period 5 through a bench-side decoder
        writeEncoder = 1'b1; setEncoderData = 32'd0;
        tick();
        writeEncoder = 1'b0;
        dec_pos = 0; dec_bad = 0;
        prev_fb = {pinEncoderF, pinEncoderB};
        loop_run(32'd1000, 5100, 0);
        loop_run(-32'sd250, 1300, 1);
        check("loop_decoded", 0, 32'(dec_pos), 32'd750);
        check("loop_position", 0, position, 32'd750);
        check("loop_illegal_jumps", 0, 32'(dec_bad), 32'd0);

        // asynchronous reset mid-run
        cmd_valid = 1'b1; cmd_steps = 32'd10; cmd_period = 16'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("prereset_busy", 0, 32'(busy), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_ctl", 0, 32'(ctl_now()), 32'(5'b1_0_0_00));
        check("async_reset_pos", 0, position, 32'd0);
        tick();
        #3;
        resetn = 1'b1;
        tick();
        check("post_reset_ctl", 0, 32'(ctl_now()), 32'(5'b1_0_0_00));
        check("post_reset_pos", 0, position, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/quad_encoder_gen.md
Name: quad_encoder_gen

Overview:
- Quadrature transmitter: produces the two-phase F/B pin pattern that the `encoder` block decodes.
- Used for hardware-in-loop motor emulation and for self-test of encoderL/encoderR.
- Driven from an iomem register slice through a valid/ready command handshake.
- Keeps a signed running position with a software-load port that mirrors the `encoder` write interface.

Parameters:
- CNT_W, 32: width of step count, position and setEncoderData.
- DIV_W, 16: width of the edge-period divider.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block is idle and accepts a command.
- cmd_steps  in  CNT_W  signed edge count: >0 forward, <0 reverse.
- cmd_period  in  DIV_W  clk cycles between edges; 0 is treated as 1.
- abort  in  1  stop the current run.
- writeEncoder  in  1  load position.
- setEncoderData  in  CNT_W  position load value.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse on normal completion.
- position  out  CNT_W  signed running edge count.
- pinEncoderF  out  1  phase F.
- pinEncoderB  out  1  phase B.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, phase 00, both pins 0, position 0.
  - done 0, busy 0, cmd_ready 1, divider 0, remaining 0.
- Phase sequence (F,B):
  - Forward: 00 -> 10 -> 11 -> 01 -> 00 (F leads B).
  - Reverse walks the same sequence backwards.
  - One step equals one pin edge (x4 resolution). Exactly one pin toggles per step.
  - The phase persists across commands; a new run starts from the current phase.
- States: IDLE, RUN.
- IDLE:
  - cmd_ready=1, busy=0.
  - Accept on cmd_valid&&cmd_ready. Latch dir=sign(cmd_steps), remaining=|cmd_steps|, period=max(cmd_period,1). Divider loads period-1.
  - If |cmd_steps|==0: stay IDLE, done=1 next cycle, pins unchanged.
  - Otherwise go to RUN.
- RUN:
  - cmd_ready=0, busy=1.
  - Divider counts down each cycle. At 0: advance phase one step in dir, position += dir, remaining -= 1, divider reloads period-1.
  - The first edge is registered exactly `period` cycles after the acceptance edge; later edges follow every `period` cycles.
  - When the edge with remaining==1 fires: next state IDLE and done=1 in that same cycle. The pin edge and done are visible together; cmd_ready=1 from that cycle.
- cmd_steps = -2^(CNT_W-1): magnitude taken as unsigned 2^(CNT_W-1), run in reverse.
- position wraps modulo 2^CNT_W in both directions (two's complement).
- writeEncoder:
  - Position takes setEncoderData on the next edge, in any state.
  - If a step fires in the same cycle, the load wins and that step's ±1 is dropped. Pins still advance and remaining still decrements.
- abort:
  - In RUN: next state IDLE, pins hold their current phase, remaining cleared, no done pulse.
  - If abort coincides with the final edge, that edge still occurs but done is suppressed.
  - abort in IDLE is ignored.
  - abort has priority over a same-cycle command acceptance only in RUN; in IDLE cmd_valid is accepted normally.
- cmd_valid while busy: ignored, not queued. The issuer holds valid until ready.
- done is a single-cycle pulse; it is never high while busy=1 except on the completion cycle, where busy is already 0.
- Reset asserted mid-run: pins drop to 00 immediately (async), all state returns to reset values.

Test Plan:
- Reset, then cmd_steps=4, period=3 → edges at +3,+6,+9,+12 cycles after accept. Pins (F,B) go 10,11,01,00; position 4; done pulse at +12; cmd_ready high at +12.
- cmd_steps=-3, period=0 from phase 00 → one edge per cycle. Pins 01,11,10; position -3; done after the 3rd edge.
- Loopback into the `encoder` block: +1000 then -250, period 5 → decoder value equals position, 750.
- writeEncoder with setEncoderData=0x7FFFFFFF while idle, then +2 steps → position 0x80000000 then 0x80000001 (wrap). Load coinciding with an edge → position equals the loaded value exactly.
- cmd_steps=100, period 10, abort at cycle 35 after accept → exactly 3 edges, position 3, no done, cmd_ready=1 the next cycle. A cmd_valid held during the run is accepted only after abort.
- cmd_steps=0 → no pin change, done pulse one cycle after accept. resetn pulsed low mid-run → pins 00, position 0, busy 0 without a clock edge.
